// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light monitor: lamp codes, default phase
// durations and error-flag bit positions.
package semaforo_pkg;

   localparam logic [2:0] VERDE_C    = 3'b100;
   localparam logic [2:0] AMARELO_C  = 3'b010;
   localparam logic [2:0] VERMELHO_C = 3'b001;

   localparam int unsigned VERDE_DEF    = 8;
   localparam int unsigned AMARELO_DEF  = 2;
   localparam int unsigned VERMELHO_DEF = 6;

   localparam int unsigned ERR_CODIGO = 2;
   localparam int unsigned ERR_TRANS  = 1;
   localparam int unsigned ERR_DUR    = 0;

   function automatic logic codigo_legal(input logic [2:0] c);
      return (c == VERDE_C) || (c == AMARELO_C) || (c == VERMELHO_C);
   endfunction

   // green -> yellow -> red -> green is a right rotation of the one-hot code
   function automatic logic [2:0] proxima_fase(input logic [2:0] fase);
      return {fase[0], fase[2:1]};
   endfunction

endpackage

// File: rtl/semaforo_canal_chk.sv
// Per-light checker: code decode, phase tracking, transition check and optional
// phase-duration check (enabled by DUR_EN).
module semaforo_canal_chk
   import semaforo_pkg::*;
#(
   parameter int unsigned TEMPO_W  = 16,
   parameter int unsigned VERDE    = VERDE_DEF,
   parameter int unsigned AMARELO  = AMARELO_DEF,
   parameter int unsigned VERMELHO = VERMELHO_DEF,
   parameter bit          DUR_EN   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [2:0] code,
   output logic [2:0] err,
   output logic       ciclo
);

   logic [2:0]         prev;
   logic               synced;
   logic               parcial;
   logic [TEMPO_W-1:0] cnt;
   logic [TEMPO_W-1:0] esperado;
   logic               legal;
   logic               mudou;
   logic               trans_ok;
   logic               dur_bad;

   assign legal    = codigo_legal(code);
   assign mudou    = legal && synced && (code != prev);
   assign trans_ok = (code == proxima_fase(prev));
   assign ciclo    = mudou && trans_ok && (prev == VERMELHO_C);

   always_comb begin
      esperado = TEMPO_W'(VERMELHO);
      case (prev)
         VERDE_C:   esperado = TEMPO_W'(VERDE);
         AMARELO_C: esperado = TEMPO_W'(AMARELO);
         default:   esperado = TEMPO_W'(VERMELHO);
      endcase
   end

   // The phase seen first after syncing is partial and never judged
   assign dur_bad = DUR_EN && mudou && trans_ok && !parcial && (cnt != esperado);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err     <= 3'b000;
         prev    <= 3'b000;
         synced  <= 1'b0;
         parcial <= 1'b0;
         cnt     <= '0;
      end else if (clr) begin
         err     <= 3'b000;
         prev    <= 3'b000;
         synced  <= 1'b0;
         parcial <= 1'b0;
         cnt     <= '0;
      end else if (!legal) begin
         err[ERR_CODIGO] <= 1'b1;
         synced          <= 1'b0;
      end else if (!synced) begin
         prev    <= code;
         synced  <= 1'b1;
         parcial <= 1'b1;
         cnt     <= TEMPO_W'(1);
      end else if (code == prev) begin
         if (cnt != '1) begin
            cnt <= cnt + TEMPO_W'(1);
         end
      end else begin
         if (!trans_ok) begin
            err[ERR_TRANS] <= 1'b1;
         end
         if (dur_bad) begin
            err[ERR_DUR] <= 1'b1;
         end
         prev    <= code;
         parcial <= 1'b0;
         cnt     <= TEMPO_W'(1);
      end
   end

endmodule

// File: rtl/semaforo_monitor.sv
// Receive-side checker for the two-light traffic controller (observation only).
// Define SEMAFORO_MON_DUR_EN to enable light A phase-duration checking.
module semaforo_monitor
   import semaforo_pkg::*;
#(
   parameter int unsigned VERDE    = VERDE_DEF,
   parameter int unsigned AMARELO  = AMARELO_DEF,
   parameter int unsigned VERMELHO = VERMELHO_DEF,
   parameter int unsigned TEMPO_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               bt,
   input  logic [2:0]         A,
   input  logic [2:0]         B,
   output logic [2:0]         err_a,
   output logic [2:0]         err_b,
   output logic [TEMPO_W-1:0] ciclos_a,
   output logic [TEMPO_W-1:0] lat,
   output logic               lat_valid,
   output logic               lat_ovf
);

`ifdef SEMAFORO_MON_DUR_EN
   localparam bit DUR_A = 1'b1;
`else
   localparam bit DUR_A = 1'b0;
`endif

   logic               ciclo_a;
   logic               unused_ciclo_b;
   logic               bt_q;
   logic [2:0]         b_ant;
   logic               ativo;
   logic [TEMPO_W-1:0] cont;
   logic               bt_sobe;
   logic               b_verde;

   semaforo_canal_chk #(
      .TEMPO_W  (TEMPO_W),
      .VERDE    (VERDE),
      .AMARELO  (AMARELO),
      .VERMELHO (VERMELHO),
      .DUR_EN   (DUR_A)
   ) u_canal_a (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .code  (A),
      .err   (err_a),
      .ciclo (ciclo_a)
   );

   semaforo_canal_chk #(
      .TEMPO_W  (TEMPO_W),
      .VERDE    (VERDE),
      .AMARELO  (AMARELO),
      .VERMELHO (VERMELHO),
      .DUR_EN   (1'b0)
   ) u_canal_b (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .code  (B),
      .err   (err_b),
      .ciclo (unused_ciclo_b)
   );

   assign bt_sobe = bt && !bt_q;
   assign b_verde = (B == VERDE_C) && (b_ant != VERDE_C);

   // Input history (bt_q, b_ant) keeps tracking through clr so edges stay accurate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bt_q      <= 1'b0;
         b_ant     <= 3'b000;
         ativo     <= 1'b0;
         cont      <= '0;
         lat       <= '0;
         lat_valid <= 1'b0;
         lat_ovf   <= 1'b0;
         ciclos_a  <= '0;
      end else begin
         bt_q      <= bt;
         b_ant     <= B;
         lat_valid <= 1'b0;
         if (clr) begin
            ativo    <= 1'b0;
            cont     <= '0;
            lat      <= '0;
            lat_ovf  <= 1'b0;
            ciclos_a <= '0;
         end else begin
            if (ciclo_a) begin
               ciclos_a <= ciclos_a + TEMPO_W'(1);
            end
            if (ativo) begin
               if (b_verde) begin
                  lat       <= (cont == '1) ? cont : cont + TEMPO_W'(1);
                  lat_valid <= 1'b1;
                  ativo     <= 1'b0;
               end else if (cont == '1) begin
                  lat_ovf <= 1'b1;
               end else begin
                  cont <= cont + TEMPO_W'(1);
               end
            end else if (bt_sobe) begin
               // Press in the very cycle B turns green is a zero-latency measurement
               if (b_verde) begin
                  lat       <= '0;
                  lat_valid <= 1'b1;
               end else begin
                  ativo <= 1'b1;
                  cont  <= '0;
               end
            end
         end
      end
   end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Receive-side checker for the two-light traffic controller: samples the lamp codes A and B plus the pedestrian button bt every clk.
- Decodes each code into a phase and checks legal codes and the legal phase order green->yellow->red->green.
- Checks A phase durations, counts completed cycles, and measures the latency from a button press to B turning green.
- Sits beside the controller in the top-level bench/system; its flags are observation-only and never drive the controller.

Parameters:
- VERDE, 8, expected A green duration in clk cycles
- AMARELO, 2, expected A yellow duration in clk cycles
- VERMELHO, 6, expected A red duration in clk cycles
- TEMPO_W, 16, width of the phase, latency and cycle counters

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of sticky error flags, counters and latency state
- bt  in  1  pedestrian button, synchronous to clk
- A  in  3  lamp code light A: 100 green, 010 yellow, 001 red
- B  in  3  lamp code light B, same encoding
- err_a  out  3  sticky flags for A: [2] illegal code, [1] illegal transition, [0] bad duration
- err_b  out  3  sticky flags for B: [2] illegal code, [1] illegal transition, [0] reserved, always 0
- ciclos_a  out  TEMPO_W  completed A cycles (red->green transitions)
- lat  out  TEMPO_W  last measured button-to-B-green latency
- lat_valid  out  1  one-cycle pulse when lat updates
- lat_ovf  out  1  sticky flag: latency counter saturated

Behaviour:
- Reset (rst=0, async): all outputs 0; both channels unsynced; phase counters 0; latency measurement idle.
- Per channel, on each posedge:
  - Store the previous code in prev.
  - Code not in {100, 010, 001}: set err[2]. Neither prev nor the counter is updated. Channel becomes unsynced.
  - Code == prev: phase counter increments, saturating at all-ones.
- Code change between legal codes:
  - Legal transitions are 100->010, 010->001 and 001->100. Any other change sets err[1].
  - The counter restarts at 1, since the new phase includes the current sample.
- Sync:
  - The first legal code after reset, clr or an illegal code sets prev and makes the channel synced.
  - No transition or duration check is made on that first code.
  - The first completed phase after syncing is not duration-checked, because it is partial.
- Duration (A only):
  - On a legal change, the count of samples in the phase just ended must equal VERDE, AMARELO or VERMELHO for green, yellow or red respectively.
  - Otherwise set err_a[0].
- ciclos_a increments on every legal A change 001->100, with wrap-around.
- Latency:
  - A rising edge of bt (registered edge detect, bt=1 and previous bt=0) while idle starts a counter at 0.
  - The counter increments each cycle.
  - When B goes to 100 from a different code: lat <= counter+1, lat_valid=1 for one cycle, return to idle.
  - Further bt edges while measuring are ignored.
  - At all-ones the counter saturates and sets lat_ovf; the measurement stays active.
  - A bt edge in the same cycle B turns green: counts as a completed measurement with lat=0.
- Error flags are sticky until clr or reset. clr has priority over same-cycle error setting, and also returns the channels to unsynced.
- Latency from input sample to flag: one clk (registered outputs).

Optional Feature:
- Macro SEMAFORO_MON_DUR_EN.
- Defined: A duration checking is active as above.
- Undefined: the duration comparators are removed and err_a[0] is tied 0. Transition/code checks, ciclos_a and latency are unchanged.

Decomposition:
- Package semaforo_pkg:
  - lamp code constants VERDE_C=3'b100, AMARELO_C=3'b010, VERMELHO_C=3'b001
  - default durations
  - error-bit index constants
- Sub-module semaforo_canal_chk (one instance each for A and B) holds:
  - code decode
  - prev register
  - sync flag
  - phase counter
  - transition check
  - duration check, enabled by an instance parameter (on for A, off for B)
- Latency logic and ciclos_a stay in the top module.

Test Plan:
- Legal A stream from reset: 8 green, 2 yellow, 6 red, repeated 3x -> err_a=000; ciclos_a=3 after the third red->green (the partial first phase is not duration-checked).
- A green held 9 cycles after sync -> err_a[0]=1 on the cycle after green->yellow; with SEMAFORO_MON_DUR_EN undefined -> err_a stays 000.
- Illegal codes:
  - A jumps 100->001 -> err_a[1]=1.
  - B driven 011 -> err_b[2]=1, B channel unsynced.
  - Then B legal -> no further flags.
- Latency:
  - bt pulse at cycle 10, B turns green at cycle 25 -> lat=15, single lat_valid pulse.
  - Second bt at cycle 12 ignored.
- clr asserted with flags set and an error on the same cycle -> all flags 0 next cycle.
- rst low mid-phase -> all outputs 0 immediately (async); after release, the first phase produces no duration error.
